// File: rtl/square_pkg.sv
// Shared widths, response-stage state encoding and a constant clog2 helper
// for the square lookup arbiter.
package square_pkg;

  localparam int SQ_IN_W  = 3;
  localparam int SQ_OUT_W = 6;

  typedef enum logic {
    RSP_EMPTY,
    RSP_FULL
  } rsp_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/square_lut.sv
// Combinational 3-bit to 6-bit squaring table.
module square_lut
  import square_pkg::*;
(
  input  logic [SQ_IN_W-1:0]  operand,
  output logic [SQ_OUT_W-1:0] square
);

  always_comb begin
    square = '0;
    case (operand)
      3'd0: square = 6'd0;
      3'd1: square = 6'd1;
      3'd2: square = 6'd4;
      3'd3: square = 6'd9;
      3'd4: square = 6'd16;
      3'd5: square = 6'd25;
      3'd6: square = 6'd36;
      3'd7: square = 6'd49;
      default: square = '0;
    endcase
  end

endmodule

// File: rtl/square_lookup_arbiter.sv
// Round-robin arbitration of NUM_REQ operand sources onto one squaring LUT,
// returning tagged results through a single-entry registered response stage.
module square_lookup_arbiter
  import square_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*SQ_IN_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [SQ_OUT_W-1:0]         rsp_square,
  output logic [ID_W-1:0]             rsp_id,
  output logic [CNT_W-1:0]            done_count
);

  localparam int unsigned NR = NUM_REQ;

  if (ID_W != clog2(NUM_REQ)) begin : g_bad_id_w
    $error("ID_W must equal clog2(NUM_REQ)");
  end

  rsp_state_t           state;
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      ptr_next;
  logic [ID_W-1:0]      grant_idx;
  logic [NUM_REQ-1:0]   grant_oh;
  logic                 found;
  logic                 can_accept;
  logic                 transfer;
  logic [SQ_IN_W-1:0]   ops [NUM_REQ];
  logic [SQ_IN_W-1:0]   grant_op;
  logic [SQ_OUT_W-1:0]  lut_square;
  int unsigned          sum;
  logic [ID_W-1:0]      cand;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ops
    assign ops[i] = req_data[i*SQ_IN_W +: SQ_IN_W];
  end

  assign can_accept = (state == RSP_EMPTY) || rsp_ready;

  // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = 0;
    cand      = '0;
    for (int unsigned off = 0; off < NR; off++) begin
      sum  = 32'(ptr) + off;
      cand = ID_W'(sum % NR);
      if (!found && req_valid[cand]) begin
        found          = 1'b1;
        grant_idx      = cand;
        grant_oh[cand] = 1'b1;
      end
    end
  end

  assign req_ready = (found && can_accept && !rst) ? grant_oh : '0;
  assign transfer  = |req_ready;
  assign grant_op  = ops[grant_idx];
  assign ptr_next  = (32'(grant_idx) == NR - 1) ? '0 : grant_idx + 1'b1;
  assign rsp_valid = (state == RSP_FULL);

  square_lut u_lut (
    .operand (grant_op),
    .square  (lut_square)
  );

  // A grant while FULL only happens with rsp_ready high, so the old result
  // drains and the new one loads on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RSP_EMPTY;
      rsp_square <= '0;
      rsp_id     <= '0;
      done_count <= '0;
      ptr        <= '0;
    end else begin
      if (rsp_valid && rsp_ready) done_count <= done_count + 1'b1;
      if (transfer) begin
        state      <= RSP_FULL;
        rsp_square <= lut_square;
        rsp_id     <= grant_idx;
        ptr        <= ptr_next;
      end else if (state == RSP_FULL && rsp_ready) begin
        state <= RSP_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_square_lookup_arbiter.sv
// Self-checking bench for square_lookup_arbiter: cycle model with response
// scoreboard, LUT vector table and hand-written corner-case sequences.
module tb_square_lookup_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [11:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [5:0]  rsp_square;
  logic [1:0]  rsp_id;
  logic [15:0] done_count;

  square_lookup_arbiter #(.NUM_REQ(4), .ID_W(2), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_square (rsp_square),
    .rsp_id     (rsp_id),
    .done_count (done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] sq;
    logic [1:0] id;
  } rsp_t;

  typedef struct {
    logic [2:0] op;
    logic [5:0] sq;
  } lut_vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  rsp_t        sb [$];
  int          grant_log [$];
  int          m_ptr  = 0;
  logic        m_full = 1'b0;
  logic [15:0] m_done = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [2:0] v);
    req_data[i*3 +: 3] = v;
  endtask

  // Reference model evaluated mid-cycle; state updates mirror the next edge.
  always @(negedge clk) begin
    logic       accept;
    logic [3:0] exp_oh;
    int         g;
    int         opi;
    rsp_t       head;
    if (rst) begin
      check("ready_in_reset", 32'(req_ready), 32'd0);
      m_ptr  = 0;
      m_full = 1'b0;
      m_done = '0;
      sb.delete();
    end else begin
      check("done_count", 32'(done_count), 32'(m_done));
      check("rsp_valid", 32'(rsp_valid), 32'(m_full));
      if (m_full) begin
        if (sb.size() == 0) begin
          check("sb_nonempty", 32'd0, 32'd1);
        end else begin
          head = sb[0];
          check("rsp_square", 32'(rsp_square), 32'(head.sq));
          check("rsp_id", 32'(rsp_id), 32'(head.id));
        end
      end
      accept = !m_full || rsp_ready;
      g = -1;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (g < 0 && req_valid[c]) g = c;
      end
      exp_oh = (accept && g >= 0) ? (4'b0001 << g) : 4'b0000;
      check("req_ready", 32'(req_ready), 32'(exp_oh));
      for (int k = 0; k < 4; k++) begin
        if (req_ready[k]) begin
          grant_log.push_back(k);
          break;
        end
      end
      if (m_full && rsp_ready) begin
        if (sb.size() > 0) void'(sb.pop_front());
        m_done = m_done + 16'd1;
        m_full = 1'b0;
      end
      if (accept && g >= 0) begin
        opi = int'(req_data[g*3 +: 3]);
        sb.push_back({6'(opi * opi), 2'(g)});
        m_full = 1'b1;
        m_ptr  = (g + 1) % 4;
      end
    end
  end

  task automatic check_log(input string name, input int exp []);
    check({name, "_len"}, 32'(grant_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < grant_log.size(); i++)
      check(name, 32'(grant_log[i]), 32'(exp[i]));
  endtask

  initial begin
    lut_vec_t lut_vecs [8];
    int       exp_sq [4];
    lut_vecs[0] = '{3'd0, 6'd0};
    lut_vecs[1] = '{3'd1, 6'd1};
    lut_vecs[2] = '{3'd2, 6'd4};
    lut_vecs[3] = '{3'd3, 6'd9};
    lut_vecs[4] = '{3'd4, 6'd16};
    lut_vecs[5] = '{3'd5, 6'd25};
    lut_vecs[6] = '{3'd6, 6'd36};
    lut_vecs[7] = '{3'd7, 6'd49};
    exp_sq = '{49, 36, 9, 4};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_square", 32'(rsp_square), 32'd0);
    check("reset_id", 32'(rsp_id), 32'd0);
    check("reset_done", 32'(done_count), 32'd0);
    rst = 1'b0;

    // Single requester
    set_op(0, 3'd5);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1 check("single_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    check("single_valid", 32'(rsp_valid), 32'd1);
    check("single_square", 32'(rsp_square), 32'd25);
    check("single_id", 32'(rsp_id), 32'd0);
    check("single_done0", 32'(done_count), 32'd0);
    tick();
    check("single_done1", 32'(done_count), 32'd1);
    check("single_empty", 32'(rsp_valid), 32'd0);

    // All four back to back, from pointer 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_op(0, 3'd7); set_op(1, 3'd6); set_op(2, 3'd3); set_op(3, 3'd2);
    req_valid = 4'b1111;
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("b2b_square", 32'(rsp_square), 32'(exp_sq[i]));
      check("b2b_id", 32'(rsp_id), 32'(i));
    end
    req_valid = '0;
    check_log("b2b_grant", '{0, 1, 2, 3});
    req_valid = 4'b1111;
    #1 check("wrap_ready", 32'(req_ready), 32'b0001);
    req_valid = '0;
    tick();

    // Backpressure holding 16/id2
    set_op(0, 3'd1); set_op(1, 3'd2); set_op(2, 3'd4); set_op(3, 3'd5);
    req_valid = 4'b0100;
    tick();
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_square", 32'(rsp_square), 32'd16);
      check("bp_id", 32'(rsp_id), 32'd2);
      check("bp_valid", 32'(rsp_valid), 32'd1);
    end
    rsp_ready = 1'b1;
    #1 check("bp_release_ready", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    check("bp_next_square", 32'(rsp_square), 32'd25);
    check("bp_next_id", 32'(rsp_id), 32'd3);
    tick();

    // Fairness between requesters 0 and 2
    grant_log.delete();
    set_op(0, 3'd1); set_op(2, 3'd2);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0101;
    repeat (4) tick();
    req_valid = '0;
    check_log("fair_grant", '{0, 2, 0, 2, 0});
    tick();

    // Reset mid-stream with 9/id1 pending
    set_op(1, 3'd3);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    check("mid_square", 32'(rsp_square), 32'd9);
    check("mid_id", 32'(rsp_id), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_done", 32'(done_count), 32'd0);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1 check("mid_rst_grant", 32'(req_ready), 32'b0001);

    // Exhaustive LUT through requester 3
    req_valid = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      set_op(3, lut_vecs[i].op);
      tick();
      check("lut_square", 32'(rsp_square), 32'(lut_vecs[i].sq));
      check("lut_id", 32'(rsp_id), 32'd3);
    end
    req_valid = '0;
    tick();
    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
